// File: rtl/approx_div_pkg.sv
// Shared types and cell models for the sequential approximate divider.
// The state encoding, the exact and approximate subtractor cells, and the
// default geometry live here so the top and the row module stay consistent.
package approx_div_pkg;

  localparam int DEFAULT_W           = 8;
  localparam int DEFAULT_APPROX_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // One subtractor cell result: difference bit and borrow out.
  typedef struct packed {
    logic diff;
    logic bout;
  } cell_out_t;

  // Full subtractor: x - y - bin.
  function automatic cell_out_t exact_cell(input logic x, input logic y, input logic bin);
    cell_out_t c;
    c.diff = x ^ y ^ bin;
    c.bout = (~x & y) | (~(x ^ y) & bin);
    return c;
  endfunction

  // Approximate cell: ignores the subtrahend bit entirely, trading accuracy
  // for a much shorter cell.
  function automatic cell_out_t approx_cell(input logic x, input logic bin);
    cell_out_t c;
    c.diff = x | ~bin;
    c.bout = ~x & ~bin;
    return c;
  endfunction

endpackage

// File: rtl/approx_div_row.sv
// Single combinational restoring-divider row.
// Subtracts d from the W-bit partial remainder x through a W-cell borrow
// chain, decides the quotient bit (the extra top bit t forces a subtract),
// and restores x when the subtraction is rejected.
// Macro APPROX_DIV_EN: when defined, use_approx switches every cell of the
// row to the approximate cell; when undefined the row is always exact.
module approx_div_row
  import approx_div_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] x,
  input  logic         t,
  input  logic [W-1:0] d,
  input  logic         use_approx,
  output logic [W-1:0] r_out,
  output logic         qbit
);

  logic [W-1:0] diff;
  logic         bout_msb;

`ifndef APPROX_DIV_EN
  logic unused_use_approx;
  assign unused_use_approx = use_approx;
`endif

  // Ripple the borrow from cell 0 upward; cell 0 has no borrow in.
  always_comb begin
    logic      b;
    cell_out_t c;
    diff = '0;
    b    = 1'b0;
    for (int j = 0; j < W; j++) begin
      c = exact_cell(x[j], d[j], b);
`ifdef APPROX_DIV_EN
      if (use_approx) begin
        c = approx_cell(x[j], b);
      end
`endif
      diff[j] = c.diff;
      b       = c.bout;
    end
    bout_msb = b;
  end

  // A set top bit means the remainder already exceeds any W-bit divisor.
  assign qbit  = t | ~bout_msb;
  assign r_out = qbit ? diff : x;

endmodule

// File: rtl/approx_seq_div.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, valid/ready on both sides.
// Macro APPROX_DIV_EN: when defined, the lowest APPROX_ROWS quotient rows use
// approximate cells for operations accepted with approx_mode=1. When
// undefined, approx_mode is ignored and the block is a bit-exact divider.
module approx_seq_div
  import approx_div_pkg::*;
#(
  parameter int W           = DEFAULT_W,
  parameter int APPROX_ROWS = DEFAULT_APPROX_ROWS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  input  logic           approx_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           busy
);

  localparam int            KW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(W - 1);

  div_state_e state_reg, state_next;

  logic [KW-1:0] k_reg;        // current quotient row index
  logic          t_reg;        // top bit of the (W+1)-bit partial remainder
  logic [W-1:0]  p_reg;        // low W bits of the partial remainder
  logic [W-2:0]  n_sh_reg;     // remaining dividend bits, next one at the MSB
  logic [W-1:0]  d_reg;
  logic [W-2:0]  q_sh_reg;     // quotient bits gathered so far
  logic [W-1:0]  q_reg;
  logic [W-1:0]  r_reg;

  logic          accept;
  logic          row_last;
  logic          use_approx;
  logic          row_qbit;
  logic [W-1:0]  row_r;
  logic [W-1:0]  q_sh_next;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign row_last  = (k_reg == '0);
  assign q_sh_next = {q_sh_reg, row_qbit};

`ifdef APPROX_DIV_EN
  localparam logic [KW:0] APPROX_LIM = (KW + 1)'(APPROX_ROWS);
  logic approx_reg;

  // Capture the per-operation approximation choice at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      approx_reg <= 1'b0;
    end else if (accept) begin
      approx_reg <= approx_mode;
    end
  end

  assign use_approx = approx_reg && ({1'b0, k_reg} < APPROX_LIM);
`else
  localparam int unused_approx_rows = APPROX_ROWS;
  logic unused_approx_mode;
  assign unused_approx_mode = approx_mode;
  assign use_approx         = 1'b0;
`endif

  approx_div_row #(
    .W(W)
  ) u_row (
    .x          (p_reg),
    .t          (t_reg),
    .d          (d_reg),
    .use_approx (use_approx),
    .r_out      (row_r),
    .qbit       (row_qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (row_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and one row of the recurrence per RUN cycle; results
  // are published only on the final row so q/r never show partial values.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg    <= '0;
      t_reg    <= 1'b0;
      p_reg    <= '0;
      n_sh_reg <= '0;
      d_reg    <= '0;
      q_sh_reg <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
    end else if (accept) begin
      k_reg    <= K_TOP;
      t_reg    <= n[2*W-1];
      p_reg    <= n[2*W-2:W-1];
      n_sh_reg <= n[W-2:0];
      d_reg    <= d;
    end else if (state_reg == RUN) begin
      k_reg    <= k_reg - 1'b1;
      t_reg    <= row_r[W-1];
      p_reg    <= {row_r[W-2:0], n_sh_reg[W-2]};
      n_sh_reg <= n_sh_reg << 1;
      q_sh_reg <= q_sh_next[W-2:0];
      if (row_last) begin
        q_reg <= q_sh_next;
        r_reg <= row_r;
      end
    end
  end

  assign q = q_reg;
  assign r = r_reg;

endmodule

// File: tb/tb_approx_seq_div.sv
// Self-checking bench for approx_seq_div (W=8, APPROX_ROWS=4).
// Honours APPROX_DIV_EN the same way the design does.
module tb_approx_seq_div;

  localparam int W  = 8;
  localparam int AR = 4;
`ifdef APPROX_DIV_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] n;
  logic [W-1:0]   d;
  logic           approx_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  approx_seq_div #(.W(W), .APPROX_ROWS(AR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .approx_mode(approx_mode), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .r(r), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Long division on a (W+1)-bit running remainder; approximate rows apply
  // the approximate subtractor definition bit by bit.
  function automatic logic [2*W-1:0] model_div(input logic [2*W-1:0] nn,
                                               input logic [W-1:0] dd,
                                               input logic am);
    logic [W:0]   cur;
    logic [W:0]   sub;
    logic [W-1:0] rem;
    logic [W-1:0] qq;
    logic [W-1:0] ad;
    logic         b;
    logic         ap;
    cur = nn[2*W-1:W-1];
    rem = '0;
    qq  = '0;
    for (int k = W - 1; k >= 0; k--) begin
      ap = am && (k < AR) && APPROX_ON;
      if (ap) begin
        b = 1'b0;
        for (int j = 0; j < W; j++) begin
          ad[j] = cur[j] | ~b;
          b     = ~cur[j] & ~b;
        end
        qq[k] = cur[W] | ~b;
        rem   = qq[k] ? ad : cur[W-1:0];
      end else if (cur >= {1'b0, dd}) begin
        qq[k] = 1'b1;
        sub   = cur - {1'b0, dd};
        rem   = sub[W-1:0];
      end else begin
        qq[k] = 1'b0;
        rem   = cur[W-1:0];
      end
      if (k > 0) cur = {rem, nn[k-1]};
    end
    return {qq, rem};
  endfunction

  // Drive one operation and wait for its result (bounded); called at posedge+1.
  task automatic run_op(input logic [2*W-1:0] nn, input logic [W-1:0] dd,
                        input logic am, input logic ordy,
                        output logic [W-1:0] qq, output logic [W-1:0] rr,
                        output int lat, output bit timed_out);
    int cnt;
    cnt = 0;
    timed_out = 1'b0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    n = nn; d = dd; approx_mode = am; out_ready = ordy; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 16'($urandom); d = 8'($urandom); approx_mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    qq = q; rr = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; n = '0; d = '0; approx_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({out_valid, q, r, busy, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: out_valid=%b q=%h r=%h busy=%b in_ready=%b required 0 00 00 0 1",
               out_valid, q, r, busy, in_ready);
    end
    $display("reset: out_valid=%b q=%h r=%h busy=%b in_ready=%b", out_valid, q, r, busy, in_ready);
  endtask

  task automatic test_exact();
    logic [W-1:0] qq, rr; int lat; bit to;
    run_op(16'd100, 8'd7, 1'b0, 1'b1, qq, rr, lat, to);
    n_cmp++;
    if (to || qq !== 8'd14 || rr !== 8'd2 || lat != W) begin
      n_bad++;
      $display("FAIL exact_100_7: q=%0d r=%0d lat=%0d to=%0b required q=14 r=2 lat=%0d", qq, rr, lat, to, W);
    end
    $display("exact 100/7: q=%0d r=%0d lat=%0d", qq, rr, lat);
  endtask

  task automatic test_approx();
    logic [W-1:0] qq, rr, eq, er; int lat; bit to;
    eq = APPROX_ON ? 8'h0F : 8'd14;
    er = APPROX_ON ? 8'hFF : 8'd2;
    run_op(16'd100, 8'd7, 1'b1, 1'b1, qq, rr, lat, to);
    n_cmp++;
    if (to || qq !== eq || rr !== er) begin
      n_bad++;
      $display("FAIL approx_100_7: q=%h r=%h required q=%h r=%h", qq, rr, eq, er);
    end
    $display("approx 100/7: q=%h r=%h", qq, rr);
  endtask

  task automatic test_div_zero();
    logic [W-1:0] qq, rr; int lat; bit to;
    run_op(16'h1234, 8'h00, 1'b0, 1'b1, qq, rr, lat, to);
    n_cmp++;
    if (to || qq !== 8'hFF || rr !== 8'h34) begin
      n_bad++;
      $display("FAIL div_zero: q=%h r=%h required q=ff r=34", qq, rr);
    end
    $display("div0 1234/0: q=%h r=%h", qq, rr);
  endtask

  task automatic test_random();
    logic [W-1:0] qq, rr, dd; logic [2*W-1:0] nn, ex; logic am; int lat; bit to;
    for (int i = 0; i < 40; i++) begin
      nn = 16'($urandom);
      dd = 8'($urandom);
      if (i % 3 == 0) nn[2*W-1:W] = 8'($urandom_range(0, 32'(dd)));
      am = 1'($urandom);
      ex = model_div(nn, dd, am);
      run_op(nn, dd, am, 1'b1, qq, rr, lat, to);
      n_cmp++;
      if (to || {qq, rr} !== ex || lat != W) begin
        n_bad++;
        $display("FAIL random[%0d]: n=%h d=%h am=%b q=%h r=%h lat=%0d required q=%h r=%h lat=%0d",
                 i, nn, dd, am, qq, rr, lat, ex[2*W-1:W], ex[W-1:0], W);
      end
      $display("random[%0d] n=%h d=%h am=%b: q=%h r=%h", i, nn, dd, am, qq, rr);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] qq, rr; logic [2*W-1:0] ex; int lat; bit to; bit bad;
    ex = model_div(16'd1000, 8'd9, 1'b0);
    run_op(16'd1000, 8'd9, 1'b0, 1'b0, qq, rr, lat, to);
    n_cmp++;
    if (to || {qq, rr} !== ex) begin
      n_bad++;
      $display("FAIL bp_result: q=%h r=%h required q=%h r=%h", qq, rr, ex[2*W-1:W], ex[W-1:0]);
    end
    bad = 1'b0;
    n = 16'd77; d = 8'd3; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if ({q, r} !== ex || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL bp_hold: q=%h r=%h in_ready=%b out_valid=%b required q=%h r=%h 0 1",
               q, r, in_ready, out_valid, ex[2*W-1:W], ex[W-1:0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    ex = model_div(16'd500, 8'd21, 1'b0);
    run_op(16'd500, 8'd21, 1'b0, 1'b1, qq, rr, lat, to);
    n_cmp++;
    if (to || {qq, rr} !== ex) begin
      n_bad++;
      $display("FAIL bp_next: q=%h r=%h required q=%h r=%h", qq, rr, ex[2*W-1:W], ex[W-1:0]);
    end
    $display("backpressure: held and released, next q=%h r=%h", qq, rr);
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] qq, rr; int lat; bit to; bit seen;
    while (!in_ready) begin @(posedge clk); #1; end
    n = 16'd100; d = 8'd7; approx_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || q !== 8'h00 || r !== 8'h00) begin
      n_bad++;
      $display("FAIL midop_reset: out_valid=%b busy=%b in_ready=%b q=%h r=%h required 0 0 1 00 00",
               out_valid, busy, in_ready, q, r);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL midop_no_valid: out_valid seen=1 required 0");
    end
    run_op(16'd255, 8'd16, 1'b0, 1'b1, qq, rr, lat, to);
    n_cmp++;
    if (to || qq !== 8'd15 || rr !== 8'd15) begin
      n_bad++;
      $display("FAIL midop_next: q=%0d r=%0d required q=15 r=15", qq, rr);
    end
    $display("reset mid-op then 255/16: q=%0d r=%0d", qq, rr);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qq, rr, dd; logic [2*W-1:0] nn, ex; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      nn = 16'($urandom_range(0, 2000));
      dd = 8'($urandom_range(9, 255));
      ex = model_div(nn, dd, 1'b0);
      run_op(nn, dd, 1'b0, 1'b1, qq, rr, lat, to);
      n_cmp++;
      if (to || {qq, rr} !== ex || lat != W) begin
        n_bad++;
        $display("FAIL b2b[%0d]: q=%h r=%h lat=%0d required q=%h r=%h lat=%0d",
                 i, qq, rr, lat, ex[2*W-1:W], ex[W-1:0], W);
      end
      $display("b2b[%0d] n=%0d d=%0d: q=%0d r=%0d", i, nn, dd, qq, rr);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_div_zero();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
